// File: rtl/axis_accum_node.sv
// ---------------------------------------------------------------------------
// axis_accum_node
//
// Packet-reduction endpoint that sits downstream of a mesh output port.
// Every incoming AXI-Stream packet (delimited by TLAST) is reduced to a
// modular sum of its words and a saturating word count. The result is sent
// back into the mesh as a short packet addressed to DEST_ID:
//   word 0 : sum            (TLAST=0)
//   word 1 : count          (TLAST=1, or 0 when the XOR check is built in)
//   word 2 : XOR of words   (TLAST=1, only with ACCUM_XOR_CHK_EN defined)
//
// Optional feature macro: ACCUM_XOR_CHK_EN
//   Defined   -> a running XOR is kept and appended as a third result word.
//   Undefined -> the result packet is exactly two words.
//
// Ports
//   CLK, RST_N       : clock, asynchronous active-low reset
//   AXIS_S_*         : input stream (TDEST is ignored)
//   AXIS_M_*         : result stream, TDEST driven with DEST_ID
//
// The input side is stalled (TREADY=0) for the whole send phase; nothing is
// dropped. All outputs are registered.
// ---------------------------------------------------------------------------
module axis_accum_node #(
    parameter int unsigned         TDATAW  = 32,
    parameter int unsigned         TDESTW  = 4,
    parameter int unsigned         CNTW    = 16,
    parameter logic [TDESTW-1:0]   DEST_ID = 4'd1
) (
    input  logic              CLK,
    input  logic              RST_N,
    // input stream
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    // result stream
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST
);

    typedef enum logic [1:0] {
        StAccum,
        StSendSum,
        StSendCnt
`ifdef ACCUM_XOR_CHK_EN
        ,
        StSendXor
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_d;

    logic [TDATAW-1:0] r_sum;
    logic [TDATAW-1:0] w_sum_d;
    logic [CNTW-1:0]   r_count;
    logic [CNTW-1:0]   w_count_d;
`ifdef ACCUM_XOR_CHK_EN
    logic [TDATAW-1:0] r_xor;
    logic [TDATAW-1:0] w_xor_d;
`endif

    logic              r_s_tready;
    logic              w_s_tready_d;
    logic              r_m_tvalid;
    logic              w_m_tvalid_d;
    logic [TDATAW-1:0] r_m_tdata;
    logic [TDATAW-1:0] w_m_tdata_d;
    logic              r_m_tlast;
    logic              w_m_tlast_d;
    logic [TDESTW-1:0] r_m_tdest;
    logic [TDESTW-1:0] w_m_tdest_d;

    logic              w_s_hs;
    logic              w_m_hs;
    logic [TDATAW-1:0] w_sum_add;
    logic [CNTW-1:0]   w_count_inc;

    // Input TDEST is deliberately not checked.
    logic              w_unused;
    assign w_unused = ^AXIS_S_TDEST;

    assign w_s_hs    = AXIS_S_TVALID & r_s_tready;
    assign w_m_hs    = r_m_tvalid & AXIS_M_TREADY;
    // Carry is discarded: sum is modulo 2^TDATAW.
    assign w_sum_add = r_sum + AXIS_S_TDATA;
    // Counter saturates at all-ones.
    assign w_count_inc = (r_count == {CNTW{1'b1}}) ? r_count : r_count + CNTW'(1);

    // -----------------------------------------------------------------------
    // Next-state and output-register logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_sum_d      = r_sum;
        w_count_d    = r_count;
`ifdef ACCUM_XOR_CHK_EN
        w_xor_d      = r_xor;
`endif
        w_s_tready_d = r_s_tready;
        w_m_tvalid_d = r_m_tvalid;
        w_m_tdata_d  = r_m_tdata;
        w_m_tlast_d  = r_m_tlast;
        w_m_tdest_d  = r_m_tdest;

        unique case (r_state)
            StAccum: begin
                // Also raises TREADY on the first edge after reset release.
                w_s_tready_d = 1'b1;
                if (w_s_hs) begin
                    w_sum_d   = w_sum_add;
                    w_count_d = w_count_inc;
`ifdef ACCUM_XOR_CHK_EN
                    w_xor_d   = r_xor ^ AXIS_S_TDATA;
`endif
                    if (AXIS_S_TLAST) begin
                        w_s_tready_d = 1'b0;
                        w_m_tvalid_d = 1'b1;
                        w_m_tdata_d  = w_sum_add;
                        w_m_tlast_d  = 1'b0;
                        w_m_tdest_d  = DEST_ID;
                        w_state_d    = StSendSum;
                    end
                end
            end

            StSendSum: begin
                if (w_m_hs) begin
                    w_m_tdata_d = TDATAW'(r_count);
`ifdef ACCUM_XOR_CHK_EN
                    w_m_tlast_d = 1'b0;
`else
                    w_m_tlast_d = 1'b1;
`endif
                    w_state_d   = StSendCnt;
                end
            end

            StSendCnt: begin
                if (w_m_hs) begin
`ifdef ACCUM_XOR_CHK_EN
                    w_m_tdata_d  = r_xor;
                    w_m_tlast_d  = 1'b1;
                    w_state_d    = StSendXor;
`else
                    w_m_tvalid_d = 1'b0;
                    w_m_tlast_d  = 1'b0;
                    w_sum_d      = '0;
                    w_count_d    = '0;
                    w_s_tready_d = 1'b1;
                    w_state_d    = StAccum;
`endif
                end
            end

`ifdef ACCUM_XOR_CHK_EN
            StSendXor: begin
                if (w_m_hs) begin
                    w_m_tvalid_d = 1'b0;
                    w_m_tlast_d  = 1'b0;
                    w_sum_d      = '0;
                    w_count_d    = '0;
                    w_xor_d      = '0;
                    w_s_tready_d = 1'b1;
                    w_state_d    = StAccum;
                end
            end
`endif

            default: begin
                w_state_d = StAccum;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StAccum;
        end else begin
            r_state <= w_state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sum      <= '0;
            r_count    <= '0;
`ifdef ACCUM_XOR_CHK_EN
            r_xor      <= '0;
`endif
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tdest  <= '0;
        end else begin
            r_sum      <= w_sum_d;
            r_count    <= w_count_d;
`ifdef ACCUM_XOR_CHK_EN
            r_xor      <= w_xor_d;
`endif
            r_s_tready <= w_s_tready_d;
            r_m_tvalid <= w_m_tvalid_d;
            r_m_tdata  <= w_m_tdata_d;
            r_m_tlast  <= w_m_tlast_d;
            r_m_tdest  <= w_m_tdest_d;
        end
    end

    assign AXIS_S_TREADY = r_s_tready;
    assign AXIS_M_TVALID = r_m_tvalid;
    assign AXIS_M_TDATA  = r_m_tdata;
    assign AXIS_M_TLAST  = r_m_tlast;
    assign AXIS_M_TDEST  = r_m_tdest;

endmodule
